int_issue_queue: RTL
====================

Name: int_issue_queue

Overview:
- Out-of-order issue queue that feeds the integer execution block (ALU/BJU/MULDIV).
- Holds renamed integer micro-ops until both source physical registers are ready.
- Selects the oldest ready entry each cycle and presents it to the register-read/intblock stage.
- Participates in redirect flush by ROB-id age.

Parameters:
DEPTH, 8, number of queue entries (power of 2, 4..16)
PREG_W, 6, physical register index width
ROBID_W, 7, ROB id width; MSB is the wrap bit
PAYLOAD_W, 256, opaque packed payload (pc, instr, imm, sqid, prd, types, flags) carried unmodified

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enq_valid  in  1  dispatch presents a micro-op
enq_ready  out  1  queue accepts a micro-op this cycle
enq_robid  in  ROBID_W  ROB id of the dispatched op
enq_prs1  in  PREG_W  source 1 physical register
enq_prs2  in  PREG_W  source 2 physical register
enq_src1_rdy  in  1  source 1 already available at dispatch
enq_src2_rdy  in  1  source 2 already available at dispatch
enq_payload  in  PAYLOAD_W  opaque op payload
wb0_valid  in  1  writeback/wakeup port 0 valid
wb0_prd  in  PREG_W  port 0 destination preg
wb1_valid  in  1  writeback/wakeup port 1 valid
wb1_prd  in  PREG_W  port 1 destination preg
issue_valid  out  1  selected op valid
issue_ready  in  1  downstream accepts the op
issue_robid  out  ROBID_W  ROB id of the issued op
issue_prs1  out  PREG_W  regfile read address 1
issue_prs2  out  PREG_W  regfile read address 2
issue_payload  out  PAYLOAD_W  payload of the issued op
flush_valid  in  1  redirect flush
flush_robid  in  ROBID_W  ROB id of the redirecting instruction
count  out  $clog2(DEPTH)+1  number of valid entries

Behaviour:
- Age rule: A is younger than B iff (A[MSB]^B[MSB]) ^ (A[MSB-1:0] > B[MSB-1:0]). A is older than B iff (A[MSB]^B[MSB]) ^ (A[MSB-1:0] < B[MSB-1:0]).
- Reset (async, reset_n=0):
  - All entry valid bits cleared; count=0.
  - Outputs: issue_valid=0, enq_ready=1 once reset_n deasserts. All other outputs 0.
- Enqueue:
  - enq_ready = (count != DEPTH) && !flush_valid. It does not depend on issue_ready, so there is no combinational path.
  - On enq_valid && enq_ready, the lowest-indexed free entry is written at the clock edge.
  - Ready bits at insertion = enq_srcN_rdy OR (wb0_valid && wb0_prd==enq_prsN) OR (wb1_valid && wb1_prd==enq_prsN). Same-cycle wakeup is never lost.
  - A newly written entry is not selectable until the following cycle (minimum dispatch-to-issue latency is 1 cycle).
- Wakeup:
  - Every cycle, each valid entry sets srcN_rdy when any wb port matches its prsN.
  - Ready bits never clear.
  - Wakeup is visible to select on the next cycle.
- Select (combinational from registered state):
  - Candidates are valid entries with src1_rdy && src2_rdy.
  - The oldest candidate by the age rule wins. Ties are impossible because ROB ids are unique.
  - issue_valid = candidate exists && !(flush_valid && winner younger than flush_robid).
  - issue_* outputs are driven from the winner's fields; they are don't-care when issue_valid=0.
- Dequeue:
  - On issue_valid && issue_ready, the winner's valid bit clears at the edge.
  - When issue_ready=0, the winner stays and is re-selected; no other entry issues.
- Flush:
  - At the edge with flush_valid, every entry whose robid is younger than flush_robid is invalidated.
  - The entry equal to flush_robid and older entries stay.
  - No enqueue occurs that cycle.
  - Flush takes priority over wakeup for the entries it clears.
- count: updated at the edge as count + enq_fire − issue_fire − flushed_entries. It never exceeds DEPTH and never underflows.
- Full: with count==DEPTH, enq_ready=0 even if an issue fires the same cycle. Accepting again begins the following cycle.

Decomposition:
- Shared package (existing defines): ROBID_W, PREG_W, the age-compare function (is_older/is_younger), and the issue payload field offsets.
- One sub-module, isq_oldest_sel: DEPTH request bits plus robids in, one-hot grant plus valid out, built as a log2(DEPTH) tree of age comparators.

Test Plan:
1. Reset, then enqueue robid 5 with both sources ready; no issue_ready stall -> issue_valid=1 on the cycle after enqueue, issue_robid=5, count returns 0.
2. Enqueue robid 3 (prs1=10 not ready) then robid 4 (ready); wb0_prd=10 two cycles later -> robid 4 issues first, robid 3 issues the cycle after the wakeup.
3. Enqueue robid 7 with prs2=12 not ready while wb1_valid=1, wb1_prd=12 in the same cycle -> entry is ready on insertion and issues next cycle.
4. Fill 8 entries, none ready -> count=8, enq_ready=0. One wakeup issues a single op -> enq_ready=1 the next cycle, not earlier.
5. Entries robid 0x3E, 0x3F, 0x40, 0x41 across the wrap; flush_robid=0x3F -> 0x40 and 0x41 are removed, 0x3E and 0x3F stay, count drops by 2. A ready 0x40 shows issue_valid=0 during the flush cycle.
6. Winner held with issue_ready=0 for 3 cycles while an older entry becomes ready -> the older entry takes over selection. No entry is lost or duplicated; final count is correct.

Source files
------------

// File: rtl/int_issue_queue_pkg.sv
// Shared definitions for the integer issue queue.
// Holds the default widths, the ROB-id age comparators and the bit offsets of the
// opaque payload fields that downstream stages unpack.
package int_issue_queue_pkg;

  localparam int unsigned IsqPregW    = 6;
  localparam int unsigned IsqRobidW   = 7;
  localparam int unsigned IsqPayloadW = 256;

  // Payload field offsets. The queue itself never looks inside the payload.
  localparam int unsigned PayloadPcLsb    = 0;
  localparam int unsigned PayloadInstrLsb = 64;
  localparam int unsigned PayloadImmLsb   = 96;
  localparam int unsigned PayloadSqidLsb  = 160;
  localparam int unsigned PayloadPrdLsb   = 168;
  localparam int unsigned PayloadTypeLsb  = 176;
  localparam int unsigned PayloadFlagsLsb = 192;

  typedef logic [IsqRobidW-1:0] robid_t;

  // The MSB is a wrap bit: when the wrap bits differ the index comparison inverts.
  function automatic logic is_younger(input robid_t a, input robid_t b);
    return (a[IsqRobidW-1] ^ b[IsqRobidW-1]) ^ (a[IsqRobidW-2:0] > b[IsqRobidW-2:0]);
  endfunction

  function automatic logic is_older(input robid_t a, input robid_t b);
    return (a[IsqRobidW-1] ^ b[IsqRobidW-1]) ^ (a[IsqRobidW-2:0] < b[IsqRobidW-2:0]);
  endfunction

endpackage

// File: rtl/isq_oldest_sel.sv
// Oldest-request selector.
// Ports:
//   req_i   - one request bit per entry
//   robid_i - ROB id of each entry
//   gnt_o   - one-hot grant of the oldest requesting entry
//   valid_o - at least one request was present
// Built as a binary tree of age comparators (log2(DEPTH) levels), stored heap-style:
// node n has children 2n and 2n+1, leaves sit at DEPTH..2*DEPTH-1, the root is node 1.
module isq_oldest_sel
  import int_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned ROBID_W = IsqRobidW
) (
  input  logic [DEPTH-1:0]              req_i,
  input  logic [DEPTH-1:0][ROBID_W-1:0] robid_i,
  output logic [DEPTH-1:0]              gnt_o,
  output logic                          valid_o
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  logic               node_vld [1:2*DEPTH-1];
  logic [ROBID_W-1:0] node_id  [1:2*DEPTH-1];
  logic [IdxW-1:0]    node_idx [1:2*DEPTH-1];

  always_comb begin
    for (int n = 1; n < 2 * DEPTH; n++) begin
      node_vld[n] = 1'b0;
      node_id[n]  = '0;
      node_idx[n] = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      node_vld[DEPTH+i] = req_i[i];
      node_id[DEPTH+i]  = robid_i[i];
      node_idx[DEPTH+i] = IdxW'(i);
    end
    for (int n = DEPTH - 1; n >= 1; n--) begin
      // Right child wins only if it requests and the left one is absent or younger.
      if (node_vld[2*n+1] && (!node_vld[2*n] || is_older(node_id[2*n+1], node_id[2*n]))) begin
        node_vld[n] = 1'b1;
        node_id[n]  = node_id[2*n+1];
        node_idx[n] = node_idx[2*n+1];
      end else begin
        node_vld[n] = node_vld[2*n];
        node_id[n]  = node_id[2*n];
        node_idx[n] = node_idx[2*n];
      end
    end
    valid_o = node_vld[1];
    gnt_o   = '0;
    if (node_vld[1]) gnt_o[node_idx[1]] = 1'b1;
  end

endmodule

// File: rtl/int_issue_queue.sv
// Out-of-order integer issue queue.
// Holds renamed micro-ops until both sources are ready, then offers the oldest ready
// entry to register read. Participates in redirect flush by ROB-id age.
// Ports:
//   clock, reset_n              - clock, asynchronous active-low reset
//   enq_*                       - dispatch interface (valid/ready handshake)
//   wb0_*, wb1_*                - writeback wakeup broadcasts
//   issue_*                     - selected op (valid/ready handshake)
//   flush_valid, flush_robid    - redirect: drop entries younger than flush_robid
//   count                       - number of valid entries
module int_issue_queue
  import int_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned PREG_W    = IsqPregW,
  parameter int unsigned ROBID_W   = IsqRobidW,
  parameter int unsigned PAYLOAD_W = IsqPayloadW
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    enq_valid,
  output logic                    enq_ready,
  input  logic [ROBID_W-1:0]      enq_robid,
  input  logic [PREG_W-1:0]       enq_prs1,
  input  logic [PREG_W-1:0]       enq_prs2,
  input  logic                    enq_src1_rdy,
  input  logic                    enq_src2_rdy,
  input  logic [PAYLOAD_W-1:0]    enq_payload,
  input  logic                    wb0_valid,
  input  logic [PREG_W-1:0]       wb0_prd,
  input  logic                    wb1_valid,
  input  logic [PREG_W-1:0]       wb1_prd,
  output logic                    issue_valid,
  input  logic                    issue_ready,
  output logic [ROBID_W-1:0]      issue_robid,
  output logic [PREG_W-1:0]       issue_prs1,
  output logic [PREG_W-1:0]       issue_prs2,
  output logic [PAYLOAD_W-1:0]    issue_payload,
  input  logic                    flush_valid,
  input  logic [ROBID_W-1:0]      flush_robid,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned CntW = IdxW + 1;

  // Control state (reset) and entry data (no reset; only read while valid).
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] rdy1_q, rdy1_d;
  logic [DEPTH-1:0] rdy2_q, rdy2_d;
  logic [CntW-1:0]  count_q, count_d;

  logic [DEPTH-1:0][ROBID_W-1:0] robid_q;
  logic [DEPTH-1:0][PREG_W-1:0]  prs1_q;
  logic [DEPTH-1:0][PREG_W-1:0]  prs2_q;
  logic [PAYLOAD_W-1:0]          payload_q [DEPTH];

  logic [DEPTH-1:0] sel_req, sel_gnt;
  logic             sel_valid;
  logic [IdxW-1:0]  sel_idx;
  logic [IdxW-1:0]  free_idx;
  logic             free_found;
  logic             enq_fire, issue_fire;
  logic             enq_rdy1, enq_rdy2;
  logic [CntW-1:0]  flushed_cnt;

  // Select only from registered state, so a just-written entry waits one cycle.
  assign sel_req = valid_q & rdy1_q & rdy2_q;

  isq_oldest_sel #(
    .DEPTH   (DEPTH),
    .ROBID_W (ROBID_W)
  ) u_oldest_sel (
    .req_i   (sel_req),
    .robid_i (robid_q),
    .gnt_o   (sel_gnt),
    .valid_o (sel_valid)
  );

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel_gnt[i]) sel_idx = sel_idx | IdxW'(i);
    end
  end

  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_q[i] && !free_found) begin
        free_idx   = IdxW'(i);
        free_found = 1'b1;
      end
    end
  end

  // Full blocks enqueue even if an issue frees a slot this cycle; no issue->enq path.
  assign enq_ready  = (count_q != CntW'(DEPTH)) && !flush_valid;
  assign enq_fire   = enq_valid && enq_ready;

  // A winner younger than the redirect is about to be flushed and must not issue.
  assign issue_valid = sel_valid && !(flush_valid && is_younger(robid_q[sel_idx], flush_robid));
  assign issue_fire  = issue_valid && issue_ready;

  assign issue_robid   = sel_valid ? robid_q[sel_idx]   : '0;
  assign issue_prs1    = sel_valid ? prs1_q[sel_idx]    : '0;
  assign issue_prs2    = sel_valid ? prs2_q[sel_idx]    : '0;
  assign issue_payload = sel_valid ? payload_q[sel_idx] : '0;
  assign count         = count_q;

  // Same-cycle writeback counts as ready at insertion.
  assign enq_rdy1 = enq_src1_rdy || (wb0_valid && wb0_prd == enq_prs1) ||
                    (wb1_valid && wb1_prd == enq_prs1);
  assign enq_rdy2 = enq_src2_rdy || (wb0_valid && wb0_prd == enq_prs2) ||
                    (wb1_valid && wb1_prd == enq_prs2);

  always_comb begin
    valid_d     = valid_q;
    rdy1_d      = rdy1_q;
    rdy2_d      = rdy2_q;
    flushed_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rdy1_d[i] = rdy1_q[i] | (valid_q[i] && ((wb0_valid && wb0_prd == prs1_q[i]) ||
                                              (wb1_valid && wb1_prd == prs1_q[i])));
      rdy2_d[i] = rdy2_q[i] | (valid_q[i] && ((wb0_valid && wb0_prd == prs2_q[i]) ||
                                              (wb1_valid && wb1_prd == prs2_q[i])));
    end
    if (issue_fire) valid_d[sel_idx] = 1'b0;
    // An issuing winner is never younger than the flush point, so no double count.
    if (flush_valid) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && is_younger(robid_q[i], flush_robid)) begin
          valid_d[i]  = 1'b0;
          flushed_cnt = flushed_cnt + CntW'(1);
        end
      end
    end
    if (enq_fire) begin
      valid_d[free_idx] = 1'b1;
      rdy1_d[free_idx]  = enq_rdy1;
      rdy2_d[free_idx]  = enq_rdy2;
    end
    count_d = count_q + CntW'(enq_fire) - CntW'(issue_fire) - flushed_cnt;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      rdy1_q  <= '0;
      rdy2_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      rdy1_q  <= rdy1_d;
      rdy2_q  <= rdy2_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (enq_fire) begin
      robid_q[free_idx]   <= enq_robid;
      prs1_q[free_idx]    <= enq_prs1;
      prs2_q[free_idx]    <= enq_prs2;
      payload_q[free_idx] <= enq_payload;
    end
  end

endmodule
